// File: rtl/cpu_irq_arbiter_if.sv
// Memory-mapped register bus between the CPU and the interrupt arbiter.
// The CPU holds i_request until o_ready is seen; o_rdata is valid while o_ready is high.
interface cpu_irq_arbiter_if;
    logic        i_request;
    logic        i_rw;
    logic [7:0]  i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_rdata, o_ready
    );
endinterface

// File: rtl/cpu_irq_arbiter.sv
// PLIC-style interrupt arbiter with edge gateways, claim/complete, and a register bus.
// Define CPU_IRQ_ARBITER_SYNC_EN to add a two-flop synchronizer on every i_irq line.
module cpu_irq_arbiter #(
    parameter int NUM_SOURCES = 8,
    parameter int PRIO_WIDTH  = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NUM_SOURCES-1:0] i_irq,
    output logic                   o_external_interrupt,
    cpu_irq_arbiter_if.slave       bus
);
    localparam int ID_W = $clog2(NUM_SOURCES + 1);

    typedef enum logic {IDLE, ACK} state_e;

    state_e                 state_q, state_d;
    logic [NUM_SOURCES-1:0] irq_s, irq_prev_q, edges;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] in_service_q, in_service_d;
    logic [NUM_SOURCES-1:0] enable_q, enable_d;
    logic [PRIO_WIDTH-1:0]  threshold_q, threshold_d;
    logic [PRIO_WIDTH-1:0]  prio_q [NUM_SOURCES];
    logic [PRIO_WIDTH-1:0]  prio_d [NUM_SOURCES];
    logic [PRIO_WIDTH-1:0]  win_prio;
    logic [ID_W-1:0]        best_id_q, best_id_d, win_id;
    logic                   ext_q, ext_d;
    logic                   ready_q, ready_d;
    logic [31:0]            rdata_q, rdata_d, rd_val;
    logic                   access, claim, complete;
    logic [5:0]             reg_idx;
    logic                   unused_addr_lsbs;

    assign reg_idx          = bus.i_address[7:2];
    assign unused_addr_lsbs = ^bus.i_address[1:0];

`ifdef CPU_IRQ_ARBITER_SYNC_EN
    logic [NUM_SOURCES-1:0] sync1_q, sync2_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = i_irq;
`endif

    // Highest priority strictly above threshold; strict compare keeps the lowest ID on ties.
    always_comb begin
        win_prio = '0;
        win_id   = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (pending_q[k] && enable_q[k] && (prio_q[k] > threshold_q) && (prio_q[k] > win_prio)) begin
                win_prio = prio_q[k];
                win_id   = ID_W'(k + 1);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            6'd0: rd_val = 32'(pending_q);
            6'd1: rd_val = 32'(enable_q);
            6'd2: rd_val = 32'(threshold_q);
            6'd3: rd_val = 32'(best_id_q);
            default: begin
                for (int k = 0; k < NUM_SOURCES; k++) begin
                    if (reg_idx == 6'(8 + k)) rd_val = 32'(prio_q[k]);
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_request) begin
                    access  = 1'b1;
                    rdata_d = bus.i_rw ? 32'd0 : rd_val;
                    ready_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!bus.i_request) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign claim    = access && !bus.i_rw && (reg_idx == 6'd3);
    assign complete = access &&  bus.i_rw && (reg_idx == 6'd3);
    assign edges    = irq_s & ~irq_prev_q;

    // Claim/complete are applied before the gateway so a same-cycle completion re-opens the source.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        enable_d     = enable_q;
        threshold_d  = threshold_q;
        prio_d       = prio_q;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (claim && (best_id_q == ID_W'(k + 1))) begin
                pending_d[k]    = 1'b0;
                in_service_d[k] = 1'b1;
            end
            if (complete && (bus.i_wdata == 32'(k + 1))) in_service_d[k] = 1'b0;
            if (edges[k] && !pending_d[k] && !in_service_d[k]) pending_d[k] = 1'b1;
            if (access && bus.i_rw && (reg_idx == 6'(8 + k))) prio_d[k] = bus.i_wdata[PRIO_WIDTH-1:0];
        end
        if (access && bus.i_rw && (reg_idx == 6'd1)) enable_d    = bus.i_wdata[NUM_SOURCES-1:0];
        if (access && bus.i_rw && (reg_idx == 6'd2)) threshold_d = bus.i_wdata[PRIO_WIDTH-1:0];
    end

    assign best_id_d = claim ? '0 : win_id;
    assign ext_d     = !claim && (win_id != '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            enable_q     <= '0;
            threshold_q  <= '0;
            best_id_q    <= '0;
            ext_q        <= 1'b0;
            for (int k = 0; k < NUM_SOURCES; k++) prio_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            irq_prev_q   <= irq_s;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            enable_q     <= enable_d;
            threshold_q  <= threshold_d;
            best_id_q    <= best_id_d;
            ext_q        <= ext_d;
            for (int k = 0; k < NUM_SOURCES; k++) prio_q[k] <= prio_d[k];
        end
    end

    assign bus.o_ready           = ready_q;
    assign bus.o_rdata           = rdata_q;
    assign o_external_interrupt  = ext_q;
endmodule
